// File: rtl/comp_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package comp_mul_pkg;

  // Default operand width; the product is twice this wide.
  localparam int WIDTH_DEF = 32;

  // Iteration counter width for the default operand width.
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF) + 1;

  // Control states of the multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for an arbitrary operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/comp_mul_datapath.sv
// Operand latch, WIDTH+1-bit conditional adder and 2*WIDTH working shift
// register. The next value of the working register is exported so the
// controller can capture the final product on the same edge as the last step.
module comp_mul_datapath
  import comp_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] work_nxt
);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;

  // One shift-add step: add the multiplicand into the upper half when the
  // low bit is set, then shift right with the carry entering the MSB.
  always_comb begin
    addend   = work_q[0] ? {1'b0, mcand_q} : '0;
    sum      = {1'b0, work_q[2*WIDTH-1:WIDTH]} + addend;
    work_nxt = work_q;
    if (load) begin
      work_nxt = {{WIDTH{1'b0}}, multiplier};
    end else if (step) begin
      work_nxt = {sum, work_q[WIDTH-1:1]};
    end
  end

  // Working register and multiplicand latch; the multiplicand is only
  // captured when a run is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q  <= '0;
      mcand_q <= '0;
    end else begin
      work_q <= work_nxt;
      if (load) begin
        mcand_q <= multiplicand;
      end
    end
  end

endmodule

// File: rtl/comp_mul.sv
// Sequential unsigned multiplier: accepts a run in IDLE or DONE, performs
// WIDTH shift-add steps in CALC, then publishes the product and holds ready
// in DONE. Product_output only changes when an operation completes.
//
// Handshake: run is sampled on every rising edge; it is honoured only in
// IDLE or DONE (operands are latched at that edge and ready drops on it).
// ready rises on the edge that writes the new product and stays high until
// the next accepted run or reset.
module comp_mul
  import comp_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   Multiplicand_input,
  input  logic [WIDTH-1:0]   Multiplier_input,
  input  logic               run,
  output logic               ready,
  output logic [2*WIDTH-1:0] Product_output,
  output state_t             state_dbg
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             state_q;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic               load;
  logic               step;
  logic               finish;
  logic [2*WIDTH-1:0] work_nxt;

  assign state_dbg = state_q;

  comp_mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .step         (step),
    .multiplicand (Multiplicand_input),
    .multiplier   (Multiplier_input),
    .work_nxt     (work_nxt)
  );

  // Next-state and control decode.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (run) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Iteration counter: cleared on accept, advanced once per CALC step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result register and ready flag; the product is captured from the value
  // the working register takes on the final step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready          <= 1'b0;
      Product_output <= '0;
    end else if (load) begin
      ready <= 1'b0;
    end else if (finish) begin
      ready          <= 1'b1;
      Product_output <= work_nxt;
    end
  end

endmodule

// File: tb/tb_comp_mul.sv
// Directed bench for comp_mul with a queue-based scoreboard.
module tb_comp_mul;
  import comp_mul_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           run = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           ready;
  logic [2*W-1:0] prod;
  state_t         state_dbg;

  int             n_cmp = 0;
  int             n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_prod = '0;

  comp_mul #(
    .WIDTH (W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .Multiplicand_input (mcand),
    .Multiplier_input   (mplier),
    .run                (run),
    .ready              (ready),
    .Product_output     (prod),
    .state_dbg          (state_dbg)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_prod", prod, 64'd0);
    check("reset_state", 64'(state_dbg), 64'(IDLE));
    last_prod = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  // Issue one operation; hold keeps run high for that many edges after accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int hold, input string name);
    int got;
    @(negedge clk);
    #1;
    mcand  = a;
    mplier = b;
    run    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check({name, "_ready_clr"}, 64'(ready), 64'd0);
    check({name, "_prod_held"}, prod, last_prod);
    got = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      run    = (cyc <= hold);
      mcand  = $urandom;
      mplier = $urandom;
      @(posedge clk);
      #1;
      if (ready) begin
        got = cyc;
        break;
      end
    end
    run = 1'b0;
    check({name, "_latency"}, 64'(got), 64'd32);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_ready_hold"}, 64'(ready), 64'd1);
    check({name, "_done_prod"}, prod, exp);
    check({name, "_state"}, 64'(state_dbg), 64'(DONE));
    last_prod = exp;
  endtask

  // Monitor: pops the scoreboard on each ready rise and flags any product
  // change that is not a completion.
  logic           ready_q = 1'b0;
  logic [2*W-1:0] prod_prev = '0;
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (rst) begin
      if (ready && !ready_q) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ready: got product %h expected none", prod);
        end else begin
          e = exp_q.pop_front();
          check("product", prod, e);
        end
      end else if (prod !== prod_prev) begin
        n_err++;
        $display("FAIL product_hold: got %h expected %h", prod, prod_prev);
      end
    end
    ready_q   = rst ? ready : 1'b0;
    prod_prev = prod;
  end

  initial begin
    apply_reset();
    release_reset();

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "max");
    run_op(32'd94, 32'd2647, 64'h3_CBF2, 0, "small");
    run_op(32'd7, 32'd9, 64'd63, 20, "hold");
    run_op(32'd0, 32'd12345, 64'd0, 0, "zero_a");
    run_op(32'd12345, 32'd0, 64'd0, 0, "zero_b");
    run_op(32'h8000_0000, 32'd2, 64'h1_0000_0000, 0, "msb");
    run_op(32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 0, "ones_x1");
    run_op(32'd1000, 32'd1000, 64'd1000000, 0, "dec");

    // Abort an operation ten cycles into CALC.
    @(negedge clk);
    #1;
    mcand  = 32'hFFFF_FFFF;
    mplier = 32'hFFFF_FFFF;
    run    = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_ready", 64'(ready), 64'd0);
    check("abort_prod_held", prod, last_prod);
    apply_reset();
    release_reset();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "after_rst");

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/comp_mul.md
COMP_MUL -- requirements
Module: comp_mul

Interface
REQ-001 Parameter WIDTH, default 32: operand width; product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 Multiplicand_input  input  WIDTH  unsigned multiplicand; sampled only when a run is accepted.
REQ-005 Multiplier_input  input  WIDTH  unsigned multiplier; sampled only when a run is accepted.
REQ-006 run  input  1  start request; a one-cycle pulse is sufficient.
REQ-007 ready  output  1  high when Product_output holds a completed result.
REQ-008 Product_output  output  2*WIDTH  unsigned product of the last completed operation.

Function
REQ-009 The multiply SHALL be a sequential shift-add over WIDTH iterations using states IDLE, CALC and DONE.
REQ-010 Run acceptance: in IDLE or DONE, run=1 at a rising edge SHALL latch both operands, load the working register as {WIDTH zeros, multiplier}, clear the iteration counter, clear ready, and enter CALC.
REQ-011 CALC step, one per cycle: if working bit 0 is 1, add the multiplicand into the upper half with carry (WIDTH+1 bits); then shift the whole register right by 1, with the carry entering the MSB.
REQ-012 After exactly WIDTH CALC cycles, the design SHALL copy the working register to Product_output, set ready=1 and enter DONE.
REQ-013 Latency: for WIDTH=32, ready SHALL rise at the 32nd rising edge after the edge that accepted run.
REQ-014 In CALC, run SHALL be ignored; the operation continues on the originally latched operands.
REQ-015 Input changes outside run acceptance SHALL NOT affect the operation in progress or the held result.
REQ-016 Product_output SHALL change only at completion.
REQ-017 Product_output SHALL hold the previous result during a new computation.
REQ-018 ready SHALL hold 1 in DONE until the next accepted run or reset.
REQ-019 In IDLE without run, the state SHALL be retained.
REQ-020 The result SHALL be exact and unsigned; no overflow is possible (e.g. (2^32-1)^2 = 64'hFFFFFFFE00000001).
REQ-021 Zero operands SHALL yield 0 with the same latency.

Reset
REQ-022 rst=0 SHALL immediately force IDLE, ready=0, Product_output=0, counter=0 and working register=0, regardless of clk.
REQ-023 Reset asserted mid-CALC SHALL abort the operation; no partial result SHALL appear on Product_output.
REQ-024 After reset release, the first run SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-025 A shared package comp_mul_pkg SHALL hold the WIDTH default, the counter width ($clog2(WIDTH)+1) and the state enum {IDLE, CALC, DONE}.
REQ-026 One sub-module, comp_mul_datapath, SHALL contain the WIDTH+1-bit conditional adder and the 2*WIDTH shift register.
REQ-027 The FSM and counter SHALL remain in comp_mul.

Verification
REQ-028 Reset: assert rst=0 -> ready=0 and Product_output=0 immediately, without a clock edge.
REQ-029 Maximum operands: 32'hFFFFFFFF x 32'hFFFFFFFF with a one-cycle run -> ready=1 32 edges later and Product_output=64'hFFFFFFFE00000001.
REQ-030 Mid-operation reset: reset asserted 10 cycles into CALC, then released, and run re-pulsed -> the full 32-cycle operation is rerun with the correct result and no early ready.
REQ-031 Small operands: 94 x 2647 -> Product_output=248818 (64'h3CBF2) with ready=1.
REQ-032 run held high through CALC, and operands changed during CALC -> the result uses the latched operands.
REQ-033 Back-to-back: run in DONE -> ready drops on the next edge and the old product is held until the new result.
REQ-034 Zero operand: 0 x 12345 -> Product_output=0 after 32 cycles.
